hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 88 ++++++++
 rtl/md_busy_counter.sv | 39 +++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - Result-class codes (what an instruction writes back and from where)
//   - Forward select codes for the D and E operand muxes
//   - Multiply/divide latencies and counter width
//   - Tnew lookup and source-match helpers used by hazard_ctrl
package hazard_ctrl_pkg;

    // Result classes; codes above ResPc are treated as ResNw
    localparam logic [2:0] ResNw  = 3'd0;
    localparam logic [2:0] ResAlu = 3'd1;
    localparam logic [2:0] ResDm  = 3'd2;
    localparam logic [2:0] ResPc  = 3'd3;

    // D operand source select
    localparam logic [1:0] FwdDRf = 2'd0;
    localparam logic [1:0] FwdDE  = 2'd1;
    localparam logic [1:0] FwdDM  = 2'd2;
    localparam logic [1:0] FwdDW  = 2'd3;

    // E operand source select
    localparam logic [1:0] FwdENone = 2'd0;
    localparam logic [1:0] FwdEM    = 2'd1;
    localparam logic [1:0] FwdEW    = 2'd2;

    // Multiply/divide occupancy
    localparam int unsigned MdCntW    = 4;
    localparam logic [3:0]  MdMultLat = 4'd5;
    localparam logic [3:0]  MdDivLat  = 4'd10;

    typedef enum logic [1:0] {StageE, StageM, StageW} stage_e;

    // Shadow of the instruction currently in E
    typedef struct packed {
        logic [4:0] dst;
        logic [2:0] res;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md_start;
    } e_shadow_t;

    // Shadow of the instructions in M and W
    typedef struct packed {
        logic [4:0] dst;
        logic [2:0] res;
    } mw_shadow_t;

    localparam e_shadow_t  EBubble = '{dst: 5'd0, res: ResNw, rs: 5'd0, rt: 5'd0, md_start: 1'b0};
    localparam mw_shadow_t MwEmpty = '{dst: 5'd0, res: ResNw};

    // Fold unused result codes onto "no write"
    function automatic logic [2:0] res_norm(input logic [2:0] res);
        return (res > ResPc) ? ResNw : res;
    endfunction

    // Cycles until the result of an instruction in the given stage becomes available
    function automatic logic [1:0] tnew(input stage_e stage, input logic [2:0] res);
        logic [1:0] t;
        t = 2'd0;
        case (stage)
            StageE: begin
                if (res == ResAlu) begin
                    t = 2'd1;
                end else if (res == ResDm) begin
                    t = 2'd2;
                end
            end
            StageM: begin
                if (res == ResDm) begin
                    t = 2'd1;
                end
            end
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    // Source register is produced by this shadow; $0 never matches
    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst,
                                     input logic [2:0] res);
        return (src != 5'd0) && (src == dst) && (res != ResNw);
    endfunction

    // Only ALU and link results are already computed when sitting in M
    function automatic logic m_can_fwd(input logic [2:0] res);
        return (res == ResAlu) || (res == ResPc);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: occupancy counter for the multiply/divide unit.
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset, clears the count
//   load     - load load_val (takes priority over decrementing)
//   load_val - latency of the operation being started
//   busy     - count is non-zero
module md_busy_counter
    import hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [MdCntW-1:0] load_val,
    output logic              busy
);

    logic [MdCntW-1:0] count_q, count_d;

    // Decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding control for a 5-stage pipeline.
//   clk, reset            - clock, asynchronous active-low reset
//   rs_D, rt_D            - source registers of the instruction in D
//   tuse_rs_D, tuse_rt_D  - cycles until each source is consumed (3 = unused)
//   dst_D, Res_D          - destination register and result class of D
//   md_start_D, md_div_D  - D starts a mult (div=0) or div (div=1)
//   md_use_D              - D reads or writes HI/LO
//   stall                 - freeze PC and F/D, bubble into E
//   fwd_rs_D, fwd_rt_D    - D operand select (RF / E / M / W)
//   fwd_rs_E, fwd_rt_E    - E operand select (none / M / W)
//   md_busy               - multiply/divide unit occupied
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] dst_D,
    input  logic [2:0] Res_D,
    input  logic       md_start_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       md_busy
);
    import hazard_ctrl_pkg::*;

    e_shadow_t  e_q, e_d;
    mw_shadow_t m_q, w_q;

    logic stall_rs, stall_rt, data_stall, md_stall, md_load;

    // D operand select, priority E > M > W; E only supplies link values
    function automatic logic [1:0] sel_d(input logic [4:0] src,
                                         input logic [4:0] e_dst, input logic [2:0] e_res,
                                         input logic [4:0] m_dst, input logic [2:0] m_res,
                                         input logic [4:0] w_dst, input logic [2:0] w_res);
        if (src_hit(src, e_dst, e_res) && (e_res == ResPc)) begin
            return FwdDE;
        end else if (src_hit(src, m_dst, m_res) && m_can_fwd(m_res)) begin
            return FwdDM;
        end else if (src_hit(src, w_dst, w_res)) begin
            return FwdDW;
        end
        return FwdDRf;
    endfunction

    // E operand select, priority M > W
    function automatic logic [1:0] sel_e(input logic [4:0] src,
                                         input logic [4:0] m_dst, input logic [2:0] m_res,
                                         input logic [4:0] w_dst, input logic [2:0] w_res);
        if (src_hit(src, m_dst, m_res) && m_can_fwd(m_res)) begin
            return FwdEM;
        end else if (src_hit(src, w_dst, w_res)) begin
            return FwdEW;
        end
        return FwdENone;
    endfunction

    // A source stalls when its producer's result arrives later than it is needed
    assign stall_rs =
        (src_hit(rs_D, e_q.dst, e_q.res) && (tuse_rs_D < tnew(StageE, e_q.res))) ||
        (src_hit(rs_D, m_q.dst, m_q.res) && (tuse_rs_D < tnew(StageM, m_q.res)));
    assign stall_rt =
        (src_hit(rt_D, e_q.dst, e_q.res) && (tuse_rt_D < tnew(StageE, e_q.res))) ||
        (src_hit(rt_D, m_q.dst, m_q.res) && (tuse_rt_D < tnew(StageM, m_q.res)));
    assign data_stall = stall_rs || stall_rt;

    // The md_start check covers the cycle the start is in E if the counter lags it
    assign md_stall = (md_use_D || md_start_D) && (md_busy || e_q.md_start);
    assign stall    = data_stall || md_stall;

    assign fwd_rs_D = sel_d(rs_D, e_q.dst, e_q.res, m_q.dst, m_q.res, w_q.dst, w_q.res);
    assign fwd_rt_D = sel_d(rt_D, e_q.dst, e_q.res, m_q.dst, m_q.res, w_q.dst, w_q.res);
    assign fwd_rs_E = sel_e(e_q.rs, m_q.dst, m_q.res, w_q.dst, w_q.res);
    assign fwd_rt_E = sel_e(e_q.rt, m_q.dst, m_q.res, w_q.dst, w_q.res);

    always_comb begin
        e_d = EBubble;
        if (!stall) begin
            e_d.dst      = dst_D;
            e_d.res      = res_norm(Res_D);
            e_d.rs       = rs_D;
            e_d.rt       = rt_D;
            e_d.md_start = md_start_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= EBubble;
            m_q <= MwEmpty;
            w_q <= MwEmpty;
        end else begin
            e_q <= e_d;
            m_q <= '{dst: e_q.dst, res: e_q.res};
            w_q <= m_q;
        end
    end

    // Counter loads on the edge that moves the start from D into E
    assign md_load = md_start_D && !stall;

    md_busy_counter u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val (md_div_D ? MdDivLat : MdMultLat),
        .busy     (md_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, dst_D;
    logic [1:0] tuse_rs_D, tuse_rt_D;
    logic [2:0] Res_D;
    logic       md_start_D, md_div_D, md_use_D;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Signal ids for the scoreboard
    localparam int unsigned SStall = 0, SFrsD = 1, SFrtD = 2, SFrsE = 3, SFrtE = 4, SBusy = 5;

    typedef struct {
        string       tag;
        int unsigned sig;
        logic [1:0]  exp;
    } exp_t;

    exp_t sb_q[$];

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .dst_D      (dst_D),
        .Res_D      (Res_D),
        .md_start_D (md_start_D),
        .md_div_D   (md_div_D),
        .md_use_D   (md_use_D),
        .stall      (stall),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] observe(input int unsigned sig);
        case (sig)
            SStall:  return {1'b0, stall};
            SFrsD:   return fwd_rs_D;
            SFrtD:   return fwd_rt_D;
            SFrsE:   return fwd_rs_E;
            SFrtE:   return fwd_rt_E;
            SBusy:   return {1'b0, md_busy};
            default: return 2'b00;
        endcase
    endfunction

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                         input logic [1:0] trt, input logic [4:0] dst, input logic [2:0] res,
                         input logic mds, input logic mdd, input logic mdu);
        rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
        dst_D = dst; Res_D = res; md_start_D = mds; md_div_D = mdd; md_use_D = mdu;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input string tag, input int unsigned sig, input logic [1:0] exp);
        exp_t e;
        e.tag = tag; e.sig = sig; e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare every pending expectation
    task automatic drain();
        #1;
        while (sb_q.size() > 0) begin
            exp_t       e;
            logic [1:0] obs;
            e   = sb_q.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with hazardous-looking inputs present
        reset = 1'b0;
        set_d(5'd8, 5'd8, 2'd0, 2'd0, 5'd8, 3'd2, 1'b1, 1'b1, 1'b1);
        #3;
        push("rst_stall", SStall, 2'd0);
        push("rst_frsD", SFrsD, 2'd0);
        push("rst_frtD", SFrtD, 2'd0);
        push("rst_frsE", SFrsE, 2'd0);
        push("rst_frtE", SFrtE, 2'd0);
        push("rst_busy", SBusy, 2'd0);
        drain();
        #4 reset = 1'b1;
        nop();
        tick();

        // Load-use: lw $8 then a consumer with tuse=1
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 3'd2, 1'b0, 1'b0, 1'b0);
        push("lu_lw_nostall", SStall, 2'd0);
        drain();
        tick();
        set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 3'd1, 1'b0, 1'b0, 1'b0);
        push("lu_stall", SStall, 2'd1);
        push("lu_frsD_e", SFrsD, 2'd0);
        drain();
        tick();
        push("lu_clear", SStall, 2'd0);
        push("lu_frsD_m", SFrsD, 2'd0);
        drain();
        tick();
        nop();
        push("lu_frsE_w", SFrsE, 2'd2);
        push("lu_nop_nostall", SStall, 2'd0);
        drain();
        tick();

        // ALU chain: addu $3 then consumer with tuse=1
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd3, 5'd0, 2'd1, 2'd3, 5'd4, 3'd1, 1'b0, 1'b0, 1'b0);
        push("ac_nostall", SStall, 2'd0);
        push("ac_frsD", SFrsD, 2'd0);
        drain();
        tick();
        set_d(5'd0, 5'd3, 2'd3, 2'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        push("ac_frsE_m", SFrsE, 2'd1);
        push("ac_rt_nostall", SStall, 2'd0);
        push("ac_frtD_m", SFrtD, 2'd2);
        drain();
        tick();
        // ALU producer in E, consumer needs it in D
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 3'd1, 1'b0, 1'b0, 1'b0);
        push("ac_frtE_w", SFrtE, 2'd2);
        drain();
        tick();
        set_d(5'd6, 5'd0, 2'd0, 2'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        push("ac_tuse0_stall", SStall, 2'd1);
        drain();
        tick();
        push("ac_tuse0_clear", SStall, 2'd0);
        push("ac_tuse0_frsD_m", SFrsD, 2'd2);
        drain();
        tick();

        // Zero register: $0 produced in E never stalls or forwards
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        push("z_stall", SStall, 2'd0);
        push("z_frsD", SFrsD, 2'd0);
        push("z_frtD", SFrtD, 2'd0);
        drain();
        tick();

        // Double match: $5 ALU then $5 link
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 3'd3, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        push("dm_stall", SStall, 2'd0);
        push("dm_frsD_e", SFrsD, 2'd1);
        push("dm_frtD_e", SFrtD, 2'd1);
        drain();
        tick();
        set_d(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        push("dm_frsE_m", SFrsE, 2'd1);
        push("dm_frtE_m", SFrtE, 2'd1);
        push("dm_frsD_m", SFrsD, 2'd2);
        drain();
        tick();
        push("dm_frsD_w", SFrsD, 2'd3);
        push("dm_frsE_w", SFrsE, 2'd2);
        drain();
        tick();
        nop();
        tick();
        tick();

        // Mult: 5 busy cycles; a second start while busy is held off
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        push("mu_start_nostall", SStall, 2'd0);
        push("mu_idle", SBusy, 2'd0);
        drain();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
                push("mu_restart_stall", SStall, 2'd1);
            end else begin
                nop();
                push("mu_nouse_nostall", SStall, 2'd0);
            end
            push("mu_busy", SBusy, 2'd1);
            drain();
            tick();
        end
        nop();
        push("mu_done", SBusy, 2'd0);
        drain();

        // Divide then mflo: stalled for all 10 busy cycles
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        push("dv_start_nostall", SStall, 2'd0);
        drain();
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 3'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            push("dv_busy", SBusy, 2'd1);
            push("dv_mflo_stall", SStall, 2'd1);
            drain();
            tick();
        end
        push("dv_released", SStall, 2'd0);
        push("dv_idle", SBusy, 2'd0);
        drain();
        tick();

        // Async reset in cycle 4 of a divide
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 3'd1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        push("ar_busy_pre", SBusy, 2'd1);
        push("ar_stall_pre", SStall, 2'd1);
        drain();
        #1 reset = 1'b0;
        push("ar_busy_now", SBusy, 2'd0);
        push("ar_stall_now", SStall, 2'd0);
        drain();
        #3 reset = 1'b1;
        tick();
        push("ar_after_busy", SBusy, 2'd0);
        push("ar_after_stall", SStall, 2'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
